// File: rtl/bpu_pkg.sv
// Shared decode constants, counter encodings and immediate helpers for the
// pre-IF branch predictor.
package bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    function automatic logic [31:0] bimm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack: pushes past capacity overwrite the oldest
// entry, pops on empty are ignored, flush empties it.
module bpu_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  stack [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    assign top   = stack[ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && pop && count != '0) begin
            // Return-and-call: replace the top in place.
            stack[ptr] <= push_data;
        end else if (push) begin
            ptr                       <= ptr + PTR_W'(1);
            stack[ptr + PTR_W'(1)]    <= push_data;
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && count != '0) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bpu_pre_if.sv
// Pre-fetch next-PC predictor: BHT of 2-bit counters for conditional
// branches, direct JAL targets, and a RAS for returns.
module bpu_pre_if
    import bpu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pre_pc,
    output logic            pre_taken,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            ras_flush
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            rd_link;
    logic            rs1_link;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] b_target;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign rs1       = instr[19:15];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign rd_link   = is_link(rd);
    assign rs1_link  = is_link(rs1);

    // rd == rs1 with both linking is a plain call (push only), never a pop.
    assign ras_pop  = is_jalr && rs1_link && !(rd_link && rd == rs1);
    assign ras_push = (is_jal || is_jalr) && rd_link;

    assign pc_plus4 = pc + XLEN'(4);
    assign b_target = pc + XLEN'($signed(bimm(instr)));
    assign j_target = pc + XLEN'($signed(jimm(instr)));

    assign rd_idx = pc[IDX_W+1:2];
    assign wr_idx = upd_pc[IDX_W+1:2];

    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc[1:0], upd_pc[XLEN-1:IDX_W+2]};

    bpu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (if_valid && ras_push),
        .pop       (if_valid && ras_pop),
        .flush     (ras_flush),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // JAL is a static target, so it is still predicted while in reset.
    always_comb begin
        pre_pc    = pc_plus4;
        pre_taken = 1'b0;
        if (is_jal) begin
            pre_pc    = j_target;
            pre_taken = 1'b1;
        end else if (!rst) begin
            if (is_branch && bht[rd_idx][1]) begin
                pre_pc    = b_target;
                pre_taken = 1'b1;
            end else if (is_jalr && ras_pop && !ras_empty) begin
                pre_pc    = ras_top;
                pre_taken = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (upd_taken && bht[wr_idx] != ST) begin
                bht[wr_idx] <= bht[wr_idx] + 2'd1;
            end else if (!upd_taken && bht[wr_idx] != SNT) begin
                bht[wr_idx] <= bht[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpu_pre_if.sv
// Bench for bpu_pre_if: directed vector table, hand-written RAS/reset
// sequences, then randomized traffic against a queue/array reference model.
module tb_bpu_pre_if;

    localparam int unsigned XLEN = 32;
    localparam logic [6:0] M_BRANCH = 7'b1100011;
    localparam logic [6:0] M_JAL    = 7'b1101111;
    localparam logic [6:0] M_JALR   = 7'b1100111;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pre_pc;
    logic            pre_taken;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            ras_flush;

    always #5 clk = ~clk;

    bpu_pre_if #(
        .XLEN      (XLEN),
        .BHT_DEPTH (64),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .instr     (instr),
        .pc        (pc),
        .pre_pc    (pre_pc),
        .pre_taken (pre_taken),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .ras_flush (ras_flush)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: counter values as integers, RAS as a bounded queue.
    int          m_bht [64];
    logic [31:0] m_ras [$];

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        int sh;
        sh = 32 - bits;
        return $unsigned($signed(v << sh) >>> sh);
    endfunction

    function automatic bit m_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    function automatic logic [31:0] m_bimm(input logic [31:0] i);
        logic [31:0] v;
        v = 32'(i[31]) * 4096 + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
        return sext(v, 13);
    endfunction

    function automatic logic [31:0] m_jimm(input logic [31:0] i);
        logic [31:0] v;
        v = 32'(i[31]) * 1048576 + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048
            + 32'(i[30:21]) * 2;
        return sext(v, 21);
    endfunction

    task automatic model_predict(output logic [31:0] npc, output logic tk);
        logic [4:0] rd;
        logic [4:0] rs;
        rd  = instr[11:7];
        rs  = instr[19:15];
        npc = pc + 32'd4;
        tk  = 1'b0;
        if (instr[6:0] == M_JAL) begin
            npc = pc + m_jimm(instr);
            tk  = 1'b1;
        end else if (!rst) begin
            if (instr[6:0] == M_BRANCH && m_bht[(pc / 4) % 64] >= 2) begin
                npc = pc + m_bimm(instr);
                tk  = 1'b1;
            end else if (instr[6:0] == M_JALR && m_link(rs) && !(m_link(rd) && rd == rs)
                         && m_ras.size() > 0) begin
                npc = m_ras[$];
                tk  = 1'b1;
            end
        end
    endtask

    task automatic m_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
    endtask

    task automatic model_update();
        logic [4:0] rd;
        logic [4:0] rs;
        int         k;
        rd = instr[11:7];
        rs = instr[19:15];
        if (rst) begin
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            m_ras.delete();
        end else begin
            if (upd_valid) begin
                k = (upd_pc / 4) % 64;
                if (upd_taken && m_bht[k] < 3) m_bht[k]++;
                else if (!upd_taken && m_bht[k] > 0) m_bht[k]--;
            end
            if (ras_flush) begin
                m_ras.delete();
            end else if (if_valid) begin
                if (instr[6:0] == M_JAL && m_link(rd)) m_push(pc + 32'd4);
                if (instr[6:0] == M_JALR) begin
                    if (!m_link(rd) && m_link(rs)) begin
                        if (m_ras.size() > 0) void'(m_ras.pop_back());
                    end else if (m_link(rd) && !m_link(rs)) begin
                        m_push(pc + 32'd4);
                    end else if (m_link(rd) && m_link(rs) && rd != rs) begin
                        if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = pc + 32'd4;
                        else m_push(pc + 32'd4);
                    end else if (m_link(rd) && m_link(rs)) begin
                        m_push(pc + 32'd4);
                    end
                end
            end
        end
    endtask

    // One clock: drive, check on the falling edge, advance the model on the rising edge.
    task automatic apply(input string name, input bit r, input bit iv, input logic [31:0] ins,
                         input logic [31:0] p, input bit uv, input logic [31:0] up,
                         input bit ut, input bit fl, input bit use_model,
                         input logic [31:0] e_pc, input bit e_tk);
        logic [31:0] want_pc;
        logic        want_tk;
        rst       = r;
        if_valid  = iv;
        instr     = ins;
        pc        = p;
        upd_valid = uv;
        upd_pc    = up;
        upd_taken = ut;
        ras_flush = fl;
        @(negedge clk);
        want_pc = e_pc;
        want_tk = e_tk;
        if (use_model) model_predict(want_pc, want_tk);
        vectors++;
        if (pre_pc !== want_pc || pre_taken !== want_tk) begin
            miscompares++;
            $display("FAIL %s: pc=%h instr=%h got pre_pc=%h pre_taken=%b, expected %h %b",
                     name, p, ins, pre_pc, pre_taken, want_pc, want_tk);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          iv;
        logic [31:0] ins;
        logic [31:0] p;
        bit          uv;
        logic [31:0] up;
        bit          ut;
        bit          fl;
        logic [31:0] e_pc;
        bit          e_tk;
    } vec_t;

    vec_t tbl [$];

    localparam logic [31:0] BEQ8   = 32'h00000463;
    localparam logic [31:0] JALM16 = 32'hFF1FF06F;
    localparam logic [31:0] CALL   = 32'h100000EF;  // jal x1, +0x100
    localparam logic [31:0] RET    = 32'h00008067;
    localparam logic [31:0] XCHG   = 32'h000082E7;  // jalr x5, 0(x1)
    localparam logic [31:0] ADDI   = 32'h00100093;

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [6];
        regs = '{5'd0, 5'd1, 5'd5, 5'd2, 5'd1, 5'd5};
        return regs[$urandom_range(0, 5)];
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; instr = '0; pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; ras_flush = 1'b0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        @(posedge clk);
        #1;

        //           r  iv  instr   pc      uv  upd_pc  ut fl  exp_pc    exp_tk
        tbl.push_back('{1, 0, BEQ8,   32'h100, 0, 32'h0,   0, 0, 32'h104, 0});
        tbl.push_back('{1, 1, JALM16, 32'h200, 0, 32'h0,   0, 0, 32'h1F0, 1});
        tbl.push_back('{1, 1, RET,    32'h400, 0, 32'h0,   0, 0, 32'h404, 0});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 1, 0, 32'h104, 0});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 1, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 1, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 1, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 1, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 0, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 1, 32'h100, 0, 0, 32'h108, 1});
        tbl.push_back('{0, 0, BEQ8,   32'h100, 0, 32'h100, 0, 0, 32'h104, 0});
        tbl.push_back('{0, 1, JALM16, 32'h200, 0, 32'h0,   0, 0, 32'h1F0, 1});
        tbl.push_back('{0, 0, RET,    32'h400, 0, 32'h0,   0, 0, 32'h404, 0});
        tbl.push_back('{0, 1, CALL,   32'h300, 0, 32'h0,   0, 0, 32'h400, 1});
        tbl.push_back('{0, 0, RET,    32'h400, 0, 32'h0,   0, 0, 32'h304, 1});
        tbl.push_back('{0, 1, RET,    32'h400, 0, 32'h0,   0, 0, 32'h304, 1});
        tbl.push_back('{0, 1, RET,    32'h400, 0, 32'h0,   0, 0, 32'h404, 0});
        tbl.push_back('{0, 1, CALL,   32'h300, 0, 32'h0,   0, 1, 32'h400, 1});
        tbl.push_back('{0, 1, RET,    32'h400, 0, 32'h0,   0, 0, 32'h404, 0});
        tbl.push_back('{0, 1, ADDI,   32'h500, 0, 32'h0,   0, 0, 32'h504, 0});

        foreach (tbl[i]) begin
            apply($sformatf("table[%0d]", i), tbl[i].r, tbl[i].iv, tbl[i].ins, tbl[i].p,
                  tbl[i].uv, tbl[i].up, tbl[i].ut, tbl[i].fl, 1'b0, tbl[i].e_pc, tbl[i].e_tk);
        end

        // Overflow: five calls into a 4-deep stack lose the oldest return address.
        for (int i = 1; i <= 5; i++) begin
            apply("ovf_call", 0, 1, CALL, 32'(i * 16), 0, 0, 0, 0, 0, 32'(i * 16 + 256), 1);
        end
        for (int i = 0; i < 4; i++) begin
            apply("ovf_ret", 0, 1, RET, 32'h600, 0, 0, 0, 0, 0, 32'h54 - 32'(i * 16), 1);
        end
        apply("ovf_ret_empty", 0, 1, RET, 32'h600, 0, 0, 0, 0, 0, 32'h604, 0);

        // Return-then-call replaces the top in place.
        apply("xchg_call", 0, 1, CALL, 32'h700, 0, 0, 0, 0, 0, 32'h800, 1);
        apply("xchg", 0, 1, XCHG, 32'h800, 0, 0, 0, 0, 0, 32'h704, 1);
        apply("xchg_ret", 0, 1, RET, 32'h900, 0, 0, 0, 0, 0, 32'h804, 1);
        apply("xchg_ret_empty", 0, 1, RET, 32'h900, 0, 0, 0, 0, 0, 32'h904, 0);

        // Reset mid-operation discards trained counters and stacked returns.
        apply("pre_rst_a", 0, 1, CALL, 32'h300, 1, 32'h100, 1, 0, 0, 32'h400, 1);
        apply("pre_rst_b", 0, 0, BEQ8, 32'h100, 1, 32'h100, 1, 0, 0, 32'h108, 1);
        apply("mid_rst", 1, 0, BEQ8, 32'h100, 0, 0, 0, 0, 0, 32'h104, 0);
        apply("post_rst_br", 0, 0, BEQ8, 32'h100, 0, 0, 0, 0, 0, 32'h104, 0);
        apply("post_rst_ret", 0, 1, RET, 32'h400, 0, 0, 0, 0, 0, 32'h404, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic [31:0] p;
            logic [31:0] up;
            int          kind;
            kind = $urandom_range(0, 3);
            ins  = $urandom;
            case (kind)
                0: ins[6:0] = M_BRANCH;
                1: begin ins[6:0] = M_JAL;  ins[11:7] = pick_reg(); end
                2: begin ins[6:0] = M_JALR; ins[11:7] = pick_reg(); ins[19:15] = pick_reg(); end
                default: ins[6:0] = 7'b0010011;
            endcase
            p  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            up = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            apply("random", $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ins, p,
                  $urandom_range(0, 1) == 1, up, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, 1'b1, 32'h0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
